// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO result registers
//
// Computes one operation at a time. A multiply is done as one shift-add step
// per cycle and a divide as one restoring-subtract step per cycle, over
// WIDTH cycles. A single FIX cycle follows, and the results are then
// registered into HI/LO.
//
// Build option: when MULDIV_SIGNED_EN is defined, OP[1] selects signed
// operation (MULT/DIV). The operands are reduced to magnitudes on accept,
// and FIX applies the signs. When the macro is undefined, OP[1] is ignored
// and FIX still takes one cycle, so latency does not change.
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request an operation (accepted in IDLE or DONE only)
//   op     in   [1:0] 00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   opa    in   [WIDTH] multiplicand / dividend
//   opb    in   [WIDTH] multiplier / divisor
//   abort  in   cancel in-flight operation; wins over start
//   busy   out  CALC or FIX in progress
//   done   out  one-cycle pulse, HI/LO newly valid
//   hi     out  [WIDTH] product high half / remainder
//   lo     out  [WIDTH] product low half / quotient
//   div0   out  last completed divide had a zero divisor

module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div0
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef MULDIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]    cnt;
   logic             accept;
   logic             is_div;
   logic             neg_a, neg_b;
   logic             zero_b;
   logic [WIDTH-1:0] opd;       // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc_hi;    // product high half / partial remainder
   logic [WIDTH-1:0] acc_lo;    // multiplier shifting out / quotient shifting in
   logic [WIDTH-1:0] opa_raw;   // original dividend, returned in HI on divide by zero

   // operand conditioning on accept
   logic             sgn_in, neg_a_in, neg_b_in;
   logic [WIDTH-1:0] mag_a_in, mag_b_in;

   // per-step datapath
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic             div_ok;

   // FIX-cycle results
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   assign accept = start & ~abort & ((state == S_IDLE) | (state == S_DONE));

   assign sgn_in   = SIGNED_EN & op[1];
   assign neg_a_in = sgn_in & opa[WIDTH-1];
   assign neg_b_in = sgn_in & opb[WIDTH-1];
   // The most negative value maps to itself, and that is its correct unsigned magnitude.
   assign mag_a_in = neg_a_in ? -opa : opa;
   assign mag_b_in = neg_b_in ? -opb : opb;

   assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});

   // A set top bit means borrow, so the trial subtract fails and the shifted remainder is kept.
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, opd};
   assign div_ok    = ~div_diff[WIDTH+1];

   assign prod     = {acc_hi, acc_lo};
   assign prod_fix = (neg_a ^ neg_b) ? -prod : prod;

   always_comb begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
      if (is_div) begin
         if (zero_b) begin
            fix_hi = opa_raw;
            fix_lo = '1;
         end else begin
            fix_lo = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
            fix_hi = neg_a ? -acc_hi : acc_hi;   // remainder follows dividend sign
         end
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = S_CALC;
         S_CALC: begin
            if (abort)                 state_nxt = S_IDLE;
            else if (cnt == CNT_LAST)  state_nxt = S_FIX;
         end
         S_FIX:  state_nxt = abort  ? S_IDLE : S_DONE;
         S_DONE: state_nxt = accept ? S_CALC : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      busy = (state == S_CALC) | (state == S_FIX);
      done = (state == S_DONE);
   end

   // datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_a   <= 1'b0;
         neg_b   <= 1'b0;
         zero_b  <= 1'b0;
         opd     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opa_raw <= '0;
         hi      <= '0;
         lo      <= '0;
         div0    <= 1'b0;
      end else begin
         if (accept) begin
            cnt     <= '0;
            is_div  <= op[0];
            neg_a   <= neg_a_in;
            neg_b   <= neg_b_in;
            zero_b  <= (opb == '0);
            opd     <= mag_b_in;
            acc_hi  <= '0;
            acc_lo  <= mag_a_in;
            opa_raw <= opa;
         end else if (abort) begin
            cnt <= '0;
         end else if (state == S_CALC) begin
            cnt <= cnt + CW'(1);
            if (is_div) begin
               acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end else begin
               acc_hi <= mul_sum[WIDTH:1];
               acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
         end

         if (state == S_FIX && !abort) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            div0 <= is_div & zero_b;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed table-driven bench for muldiv_unit
module tb_muldiv_unit;

   localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  opa, opb;
   logic          abort;
   logic          busy, done, div0;
   logic [W-1:0]  hi, lo;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .opa   (opa),
      .opb   (opb),
      .abort (abort),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo),
      .div0  (div0)
   );

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] ehi;
      logic [W-1:0] elo;
      logic         ediv0;
   } vec_t;

   localparam int NV = 13;
   vec_t vt [NV];

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Called at a negedge. Returns at the negedge of the DONE cycle with the
   // number of cycles since the START cycle. Also pulses START mid-CALC with junk.
   task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit busy_ok);
      start = 1'b1; op = o; opa = a; opb = b;
      @(negedge clk);
      start = 1'b0; opa = $urandom; opb = $urandom;
      lat = 1; busy_ok = 1'b1;
      while (!done && lat < 100) begin
         if (!busy) busy_ok = 1'b0;
         if (lat == 5) begin start = 1'b1; op = ~o; end
         else start = 1'b0;
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (busy) busy_ok = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, lat2, c;
      bit bok, saw_done;
      logic [W-1:0] hold_hi, hold_lo;

      vt[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1, 1'b0};
      vt[1]  = '{2'b10, 32'hFFFFFFFD, 32'h00000005, SGN ? 32'hFFFFFFFF : 32'h00000004, 32'hFFFFFFF1, 1'b0};
      vt[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vt[3]  = '{2'b01, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
      vt[4]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, SGN ? 32'hFFFFFFFF : 32'h00000001,
                 SGN ? 32'hFFFFFFFD : 32'h7FFFFFFC, 1'b0};
      vt[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, SGN ? 32'h00000000 : 32'h80000000,
                 SGN ? 32'h80000000 : 32'h00000000, 1'b0};
      vt[6]  = '{2'b01, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
      vt[7]  = '{2'b00, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
      vt[8]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
      vt[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, SGN ? 32'hFFFFFFFF : 32'h00000006, 32'hFFFFFFF2, 1'b0};
      vt[10] = '{2'b11, 32'h00000007, 32'hFFFFFFFE, SGN ? 32'h00000001 : 32'h00000007,
                 SGN ? 32'hFFFFFFFD : 32'h00000000, 1'b0};
      vt[11] = '{2'b01, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
      vt[12] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 2'b00; opa = '0; opb = '0;
      #1;
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      chk("reset_flags", {busy, done, div0}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         do_op(vt[i].op, vt[i].a, vt[i].b, lat, bok);
         chk($sformatf("v%0d_latency", i), lat, 34);
         chk($sformatf("v%0d_busy", i), bok, 1);
         chk($sformatf("v%0d_hi", i), hi, vt[i].ehi);
         chk($sformatf("v%0d_lo", i), lo, vt[i].elo);
         chk($sformatf("v%0d_div0", i), div0, vt[i].ediv0);
         hold_hi = hi; hold_lo = lo;
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", i), done, 0);
         chk($sformatf("v%0d_hold", i), {hi, lo}, {hold_hi, hold_lo});
      end

      // ABORT with START in CALC cycle 10: back to IDLE, no DONE, results kept
      start = 1'b1; op = 2'b00; opa = 32'hFFFFFFFF; opb = 32'h2;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (c < 10) begin @(negedge clk); c++; end
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      chk("abort_idle", busy, 0);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      chk("abort_no_done", saw_done, 0);
      chk("abort_keep", {hi, lo}, {32'h00000001, 32'h00000000});

      // ABORT during the DONE cycle: pulse still ends, results stay
      do_op(2'b00, 32'd3, 32'd5, lat, bok);
      chk("doneabort_lat", lat, 34);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("doneabort_state", {busy, done}, 2'b00);
      chk("doneabort_res", {hi, lo}, {32'h0, 32'h0000000F});

      // asynchronous reset in cycle 20 of a divide
      start = 1'b1; op = 2'b01; opa = 32'd1000; opb = 32'd3;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (c < 20) begin @(negedge clk); c++; end
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_hi", hi, 0);
      chk("midreset_lo", lo, 0);
      chk("midreset_flags", {busy, done, div0}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(2'b00, 32'd6, 32'd7, lat, bok);
      chk("postreset_lat", lat, 34);
      chk("postreset_lo", lo, 32'h0000002A);

      // back-to-back: second START sampled in the DONE cycle
      do_op(2'b01, 32'd100, 32'd7, lat, bok);
      chk("b2b_first_lo", lo, 32'h0000000E);
      do_op(2'b00, 32'd9, 32'd9, lat2, bok);
      chk("b2b_second_lat", lat2, 34);
      chk("b2b_second_res", {hi, lo}, {32'h0, 32'h00000051});

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal 8..64, even).
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port START  input  1  request new operation.
REQ-005 SHALL have port OP  input  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
REQ-006 SHALL have ports OPA, OPB  input  WIDTH  multiplicand/dividend, multiplier/divisor.
REQ-007 SHALL have port ABORT  input  1  cancel in-flight operation (pipeline flush).
REQ-008 SHALL have port BUSY  output  1  operation in progress.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse, HI/LO newly valid.
REQ-010 SHALL have ports HI, LO  output  WIDTH  result registers.
REQ-011 SHALL have port DIV0  output  1  last completed divide had OPB==0.

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> FIX -> DONE; DONE -> CALC if START accepted, else IDLE.
REQ-013 SHALL accept START only in IDLE or DONE, latching OP/OPA/OPB that edge; START in CALC/FIX ignored.
REQ-014 SHALL stay in CALC exactly WIDTH cycles, one shift-add (multiply) or restoring-subtract (divide) step per cycle, counter 0..WIDTH-1.
REQ-015 SHALL apply sign correction in FIX (1 cycle), then update HI/LO at entry to DONE.
REQ-016 Latency: START sampled in cycle 0, BUSY=1 cycles 1..WIDTH+1, DONE=1 and HI/LO valid in cycle WIDTH+2, BUSY=0 in DONE.
REQ-017 Multiply: {HI,LO} = full 2*WIDTH-bit product.
REQ-018 Divide: LO = quotient, HI = remainder; signed remainder takes dividend's sign, quotient truncates toward zero.
REQ-019 Divide by zero: same latency, LO = all ones, HI = OPA, DIV0=1; any other completed op clears DIV0.
REQ-020 Signed DIV of most-negative by -1: LO = most-negative, HI = 0, DIV0=0.
REQ-021 HI/LO/DIV0 SHALL hold between operations; changed only at DONE entry.
REQ-022 ABORT in CALC/FIX: IDLE next edge, HI/LO/DIV0 unchanged, no DONE.
REQ-023 ABORT and START in same cycle: ABORT wins, START dropped.
REQ-024 ABORT in IDLE/DONE: no effect on HI/LO; DONE pulse still ends after one cycle.

Reset
REQ-025 RST_N low SHALL immediately force IDLE, BUSY=0, DONE=0, HI=0, LO=0, DIV0=0, counter=0, regardless of state or clock.
REQ-026 Reset mid-operation SHALL discard the operation; first START after RST_N rises behaves per REQ-016.

Configuration
REQ-027 Macro MULDIV_SIGNED_EN defined: MULT/DIV use magnitude computation plus FIX-state sign correction per REQ-017..020.
REQ-028 Macro MULDIV_SIGNED_EN undefined: OP[1] ignored, MULT=MULTU, DIV=DIVU; FIX state still occupies one cycle (latency identical).

Verification
REQ-029 WIDTH=32, MULT OPA=FFFFFFFD OPB=00000005 -> DONE at cycle 34, HI=FFFFFFFF LO=FFFFFFF1 (MULTU same operands: HI=00000004 LO=FFFFFFF1).
REQ-030 MULTU FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE LO=00000001; DIVU 100/7 -> LO=0000000E HI=00000002.
REQ-031 DIV OPA=FFFFFFF9 (-7) OPB=00000002 -> LO=FFFFFFFD HI=FFFFFFFF; DIV 80000000/FFFFFFFF -> LO=80000000 HI=0.
REQ-032 DIVU 5/0 -> DONE cycle 34, DIV0=1, LO=FFFFFFFF HI=00000005; next MULTU 2x3 -> DIV0=0, LO=6.
REQ-033 START MULTU, ABORT at cycle 10 with START also high -> IDLE at cycle 11, no DONE, HI/LO keep prior values; START while BUSY ignored.
REQ-034 RST_N low at cycle 20 of DIVU, asynchronous to CLK -> all outputs 0 immediately; back-to-back START in DONE cycle -> second DONE exactly 34 cycles later.
